uart_word_sched: RTL and testbench

UART_WORD_SCHED -- requirements
Module: uart_word_sched

---
 rtl/uart_word_sched.sv | 131 +++++++++++++
 tb/tb_uart_word_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_sched.sv
// Word-to-byte scheduler feeding a byte-wide UART transmitter.
// Two requesters are arbitrated round-robin. Each accepted word is sent
// little-endian as len+1 bytes, with a tx_start/tx_busy handshake per byte.
module uart_word_sched #(
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        r0_valid,
  input  logic [31:0] r0_data,
  input  logic [1:0]  r0_len,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [31:0] r1_data,
  input  logic [1:0]  r1_len,
  output logic        r1_ready,
  output logic [7:0]  tx_sdata,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        idle,
  output logic        hs_err
);

  localparam int unsigned CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t         state, state_nx;
  logic [31:0]    hold;
  logic [1:0]     len_q;
  logic [1:0]     idx;
  logic [1:0]     idx_nx;
  logic           last_gnt;   // requester granted most recently
  logic [CW-1:0]  cnt;
  logic           gnt;        // 0 = requester 0, 1 = requester 1
  logic           gnt_valid;
  logic           xfer;
  logic           last_byte;
  logic           timeout;
  logic           advance;

  // Arbitration and ready generation; ready is gated by reset and IDLE.
  always_comb begin
    gnt_valid = r0_valid | r1_valid;
    if (r0_valid && r1_valid) begin
      gnt = ~last_gnt;
    end else begin
      gnt = r1_valid;
    end
    xfer     = rstn && (state == IDLE) && gnt_valid;
    r0_ready = xfer && !gnt;
    r1_ready = xfer && gnt;
    idle     = (state == IDLE);
  end

  // Next-state logic and handshake supervision.
  always_comb begin
    state_nx  = state;
    timeout   = 1'b0;
    advance   = 1'b0;
    last_byte = (idx == len_q);
    idx_nx    = idx + 2'd1;
    case (state)
      IDLE: begin
        if (xfer) state_nx = SEND;
      end
      SEND: begin
        state_nx = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_nx = WAIT_LO;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          timeout  = 1'b1;
          state_nx = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_byte) begin
            state_nx = IDLE;
          end else begin
            advance  = 1'b1;
            state_nx = SEND;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and output registers.
  // tx_sdata/tx_start are loaded on the edge that enters SEND so the pulse
  // is visible during the SEND cycle, one cycle after the transfer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_sdata <= '0;
      hs_err   <= 1'b0;
      idx      <= '0;
      len_q    <= '0;
      hold     <= '0;
      last_gnt <= 1'b1;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      tx_start <= (state_nx == SEND);
      if (xfer) begin
        hold     <= gnt ? r1_data : r0_data;
        len_q    <= gnt ? r1_len : r0_len;
        idx      <= '0;
        last_gnt <= gnt;
        tx_sdata <= gnt ? r1_data[7:0] : r0_data[7:0];
      end
      if (advance) begin
        idx      <= idx_nx;
        tx_sdata <= hold[{idx_nx, 3'b000} +: 8];
      end
      if (state == SEND) begin
        cnt <= '0;
      end else if (state == WAIT_HI) begin
        cnt <= cnt + CW'(1);
      end
      if (timeout) begin
        hs_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_sched.sv
// Self-checking bench for uart_word_sched with a transmitter model and a
// byte scoreboard.
module tb_uart_word_sched;

  logic        clk;
  logic        rstn;
  logic        r0_valid;
  logic [31:0] r0_data;
  logic [1:0]  r0_len;
  logic        r0_ready;
  logic        r1_valid;
  logic [31:0] r1_data;
  logic [1:0]  r1_len;
  logic        r1_ready;
  logic [7:0]  tx_sdata;
  logic        tx_start;
  logic        tx_busy;
  logic        idle;
  logic        hs_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_starts = 0;
  bit          busy_en = 1'b1;
  int          busy_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;

  uart_word_sched #(.BUSY_TIMEOUT(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .r0_valid (r0_valid),
    .r0_data  (r0_data),
    .r0_len   (r0_len),
    .r0_ready (r0_ready),
    .r1_valid (r1_valid),
    .r1_data  (r1_data),
    .r1_len   (r1_len),
    .r1_ready (r1_ready),
    .tx_sdata (tx_sdata),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .idle     (idle),
    .hs_err   (hs_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model and scoreboard consumer: each start pulse pops one
  // expected byte and (when enabled) makes the transmitter busy for 3 cycles.
  always @(negedge clk) begin
    if (!rstn) begin
      tx_busy  = 1'b0;
      busy_cnt = 0;
    end else if (tx_start) begin
      n_starts++;
      n_tests++;
      if (tx_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL start_while_busy: tx_busy=%b required 0", tx_busy);
      end
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_start: tx_sdata=%h with no byte expected", tx_sdata);
      end else begin
        exp_b = exp_q.pop_front();
        if (tx_sdata !== exp_b) begin
          n_fail++;
          $display("FAIL tx_byte: got %h required %h", tx_sdata, exp_b);
        end
      end
      if (busy_en) begin
        tx_busy  = 1'b1;
        busy_cnt = 3;
      end
    end else if (tx_busy && busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  task automatic push_word(input logic [31:0] d, input logic [1:0] l);
    for (int unsigned i = 0; i <= l; i++) exp_q.push_back(d[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int unsigned k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (idle !== 1'b1 && k < 300);
    n_tests++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: idle=%b required 1", name, idle);
    end
  endtask

  task automatic check_drained(input string name, input int base, input int nbytes);
    n_tests++;
    if (exp_q.size() != 0 || (n_starts - base) != nbytes) begin
      n_fail++;
      $display("FAIL %s_count: starts=%0d pending=%0d required starts=%0d pending=0",
               name, n_starts - base, exp_q.size(), nbytes);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1;
    r0_data = '0; r1_data = '0; r0_len = '0; r1_len = '0;
    tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: r0_ready=%b r1_ready=%b required 0 0", r0_ready, r1_ready);
    end
    n_tests++;
    if (tx_start !== 1'b0 || tx_sdata !== 8'h00 || hs_err !== 1'b0 || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs: tx_start=%b tx_sdata=%h hs_err=%b idle=%b required 0 00 0 1",
               tx_start, tx_sdata, hs_err, idle);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_tests++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rr_favours_r0: r0_ready=%b r1_ready=%b required 1 0", r0_ready, r1_ready);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    #1;
    n_tests++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_without_valid: r0_ready=%b r1_ready=%b required 0 0", r0_ready, r1_ready);
    end
  endtask

  task automatic test_four_byte();
    int base;
    base = n_starts;
    push_word(32'h44332211, 2'd3);
    @(negedge clk);
    r0_valid = 1'b1; r0_data = 32'h44332211; r0_len = 2'd3;
    #1;
    n_tests++;
    if (r0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL four_byte_ready: r0_ready=%b required 1", r0_ready);
    end
    @(posedge clk); #1;
    r0_valid = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL four_byte_latency: tx_start=%b required 1 one cycle after transfer", tx_start);
    end
    wait_idle("four_byte");
    check_drained("four_byte", base, 4);
  endtask

  task automatic test_round_robin();
    int base;
    int unsigned k = 0;
    base = n_starts;
    // Last grant went to requester 0, so requester 1 is served first.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hA5);
    end
    @(negedge clk);
    r0_valid = 1'b1; r0_data = 32'h000000A5; r0_len = 2'd0;
    r1_valid = 1'b1; r1_data = 32'h0000005A; r1_len = 2'd0;
    #1;
    n_tests++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_grant: r0_ready=%b r1_ready=%b required 0 1", r0_ready, r1_ready);
    end
    while ((n_starts - base) < 6 && k < 400) begin
      @(negedge clk); #1;
      k++;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_idle("round_robin");
    check_drained("round_robin", base, 6);
  endtask

  task automatic test_single();
    int base;
    base = n_starts;
    push_word(32'h000000C3, 2'd0);
    @(negedge clk);
    r1_valid = 1'b1; r1_data = 32'h000000C3; r1_len = 2'd0;
    @(posedge clk); #1;
    r1_valid = 1'b0;
    wait_idle("single");
    repeat (10) @(negedge clk);
    #1;
    check_drained("single", base, 1);
    n_tests++;
    if (idle !== 1'b1 || hs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_final: idle=%b hs_err=%b required 1 0", idle, hs_err);
    end
  endtask

  task automatic test_timeout();
    int base;
    base = n_starts;
    busy_en = 1'b0;
    push_word(32'h0000BBAA, 2'd1);
    @(negedge clk);
    r0_valid = 1'b1; r0_data = 32'h0000BBAA; r0_len = 2'd1;
    @(posedge clk); #1;
    r0_valid = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_first_start: tx_start=%b required 1", tx_start);
    end
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (hs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_err_early: hs_err=%b required 0 before timeout", hs_err);
    end
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (hs_err !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_err_set: hs_err=%b required 1 after timeout", hs_err);
    end
    wait_idle("timeout");
    check_drained("timeout", base, 2);
    repeat (5) @(negedge clk);
    #1;
    n_tests++;
    if (hs_err !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_err_sticky: hs_err=%b required 1", hs_err);
    end
    busy_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int base;
    int unsigned k = 0;
    base = n_starts;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    @(negedge clk);
    r0_valid = 1'b1; r0_data = 32'h78563412; r0_len = 2'd3;
    @(posedge clk); #1;
    r0_valid = 1'b0;
    while ((n_starts - base) < 2 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    rstn = 1'b0;
    r0_valid = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ready: r0_ready=%b r1_ready=%b required 0 0", r0_ready, r1_ready);
    end
    n_tests++;
    if (tx_start !== 1'b0 || tx_sdata !== 8'h00 || hs_err !== 1'b0 || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_outputs: tx_start=%b tx_sdata=%h hs_err=%b idle=%b required 0 00 0 1",
               tx_start, tx_sdata, hs_err, idle);
    end
    @(negedge clk);
    r0_valid = 1'b0;
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check_drained("midreset", base, 2);
    n_tests++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_idle: idle=%b required 1", idle);
    end
  endtask

  task automatic test_data_change();
    int base;
    int unsigned k = 0;
    base = n_starts;
    push_word(32'h87654321, 2'd3);
    @(negedge clk);
    r0_valid = 1'b1; r0_data = 32'h87654321; r0_len = 2'd3;
    @(posedge clk); #1;
    while ((n_starts - base) < 4 && k < 200) begin
      @(negedge clk); #1;
      k++;
      if (idle !== 1'b1) begin
        n_tests++;
        if (r0_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_ready: r0_ready=%b required 0 while word in flight", r0_ready);
        end
      end
      r0_data = $urandom;
      r0_len  = 2'($urandom_range(0, 3));
    end
    r0_valid = 1'b0;
    wait_idle("data_change");
    check_drained("data_change", base, 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_four_byte();
    test_round_robin();
    test_single();
    test_timeout();
    test_reset_mid();
    test_data_change();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
